hilo_unit: RTL and testbench

- Parametrised HI/LO special-register unit for the MIPS datapath. It supersedes the fixed 5:1 HI/LO source multiplexer.
- Selects one of NSRC write sources (MULT, MULTU, DIV, DIVU, MTHI/MTLO, ...) and writes HI and/or LO through independent enables.
- Waits, with a pipeline stall, for multicycle sources to present a ready result. Aborts on timeout.
- Provides a read port with same-cycle bypass for MFHI/MFLO.

---
 rtl/hilo_unit.sv | 137 +++++++++++++
 tb/tb_hilo_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO special registers: selects one of NSRC write sources, stalls for multicycle results,
// aborts on timeout, and gives a read port with same-cycle bypass of the committing value.
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 5,
  parameter int SELW    = 3,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [SELW-1:0]       wr_sel,
  input  logic                  wr_hi_en,
  input  logic                  wr_lo_en,
  input  logic [NSRC*WIDTH-1:0] src_hi,
  input  logic [NSRC*WIDTH-1:0] src_lo,
  input  logic [NSRC-1:0]       src_rdy,
  input  logic                  rd_sel,
  output logic [WIDTH-1:0]      rd_data,
  output logic [WIDTH-1:0]      hi,
  output logic [WIDTH-1:0]      lo,
  output logic                  stall,
  output logic                  err
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [CNTW-1:0] TMO = CNTW'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             hien_q, hien_d;
  logic             loen_q, loen_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             err_q, err_d;

  logic [SELW-1:0]  cur_sel;
  logic             cur_hien, cur_loen;
  logic             sel_ok, rdy_sel, commit;
  logic [WIDTH-1:0] hi_cand, lo_cand;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    hien_d   = hien_q;
    loen_d   = loen_q;
    err_d    = 1'b0;
    stall    = 1'b0;
    commit   = 1'b0;
    rdy_sel  = 1'b0;
    hi_cand  = '0;
    lo_cand  = '0;

    // In WAIT the pipeline is held, so only the latched request matters.
    cur_sel  = (state_q == ST_WAIT) ? sel_q  : wr_sel;
    cur_hien = (state_q == ST_WAIT) ? hien_q : wr_hi_en;
    cur_loen = (state_q == ST_WAIT) ? loen_q : wr_lo_en;
    sel_ok   = int'(cur_sel) < NSRC;

    for (int k = 0; k < NSRC; k++) begin
      if (cur_sel == SELW'(k)) begin
        rdy_sel = src_rdy[k];
        hi_cand = src_hi[k*WIDTH +: WIDTH];
        lo_cand = src_lo[k*WIDTH +: WIDTH];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_valid && (wr_hi_en || wr_lo_en)) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else if (rdy_sel) begin
            commit = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = CNTW'(1);
            sel_d   = wr_sel;
            hien_d  = wr_hi_en;
            loen_d  = wr_lo_en;
          end
        end
      end
      default: begin
        // Ready wins over a coinciding timeout.
        if (rdy_sel) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    endcase

    hi_d    = (commit && cur_hien) ? hi_cand : hi_q;
    lo_d    = (commit && cur_loen) ? lo_cand : lo_q;
    rd_data = rd_sel ? lo_d : hi_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      hien_q  <= 1'b0;
      loen_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      hien_q  <= hien_d;
      loen_q  <= loen_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign hi  = hi_q;
  assign lo  = lo_q;
  assign err = err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: table of single-cycle writes plus hand-written stall, timeout and reset sequences.
module tb_hilo_unit;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic [2:0]    wr_sel;
  logic          wr_hi_en;
  logic          wr_lo_en;
  logic [159:0]  src_hi;
  logic [159:0]  src_lo;
  logic [4:0]    src_rdy;
  logic          rd_sel;
  logic [31:0]   rd_data;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic          stall;
  logic          err;

  int checks = 0;
  int errors = 0;

  hilo_unit dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_sel   (wr_sel),
    .wr_hi_en (wr_hi_en),
    .wr_lo_en (wr_lo_en),
    .src_hi   (src_hi),
    .src_lo   (src_lo),
    .src_rdy  (src_rdy),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo),
    .stall    (stall),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic        he;
    logic        le;
    logic        rs;
    logic        e_stall;
    logic [31:0] e_rd;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_err;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v  sel  he  le  rs  stall rd            hi          lo            err
    vt[0] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11,   32'h11, 32'h22,   1'b0};
    vt[1] = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h11, 32'hDEAD, 1'b0};
    vt[2] = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11,   32'h11, 32'hDEAD, 1'b0};
    vt[3] = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11,   32'h11, 32'hDEAD, 1'b1};
    vt[4] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD, 32'h11, 32'hDEAD, 1'b0};
    vt[5] = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA1,   32'hA1, 32'hDEAD, 1'b0};
    vt[6] = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB4,   32'hA4, 32'hB4,   1'b0};
    vt[7] = '{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA4,   32'hA4, 32'hB4,   1'b0};
    vt[8] = '{1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'hB4,   32'hA4, 32'hB4,   1'b1};
    vt[9] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA4,   32'hA4, 32'hB4,   1'b0};

    src_hi   = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'h11};
    src_lo   = {32'hB4, 32'hDEAD, 32'hB2, 32'hB1, 32'h22};
    src_rdy  = 5'b11111;
    wr_valid = 1'b0;
    wr_sel   = 3'd0;
    wr_hi_en = 1'b0;
    wr_lo_en = 1'b0;
    rd_sel   = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);

    // Single-cycle writes, bypass, bad select, no-op, back to back
    for (int i = 0; i < 10; i++) begin
      wr_valid = vt[i].v;
      wr_sel   = vt[i].sel;
      wr_hi_en = vt[i].he;
      wr_lo_en = vt[i].le;
      rd_sel   = vt[i].rs;
      #1;
      chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
      chk($sformatf("vec%0d_rd", i), rd_data, vt[i].e_rd);
      tick();
      chk($sformatf("vec%0d_hi", i), hi, vt[i].e_hi);
      chk($sformatf("vec%0d_lo", i), lo, vt[i].e_lo);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].e_err});
    end

    // Multicycle source ready after 10 stalled cycles; changed wr_sel ignored
    src_rdy  = 5'b11011;
    wr_valid = 1'b1;
    wr_sel   = 3'd2;
    wr_hi_en = 1'b1;
    wr_lo_en = 1'b1;
    rd_sel   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("wait_stall_c%0d", c), {31'b0, stall}, 32'h1);
      chk($sformatf("wait_rd_c%0d", c), rd_data, 32'hA4);
      tick();
      wr_sel = 3'd0;
    end
    src_rdy = 5'b11111;
    #1;
    chk("wait_done_stall", {31'b0, stall}, 32'h0);
    chk("wait_done_bypass", rd_data, 32'hA2);
    tick();
    wr_valid = 1'b0;
    chk("wait_done_hi", hi, 32'hA2);
    chk("wait_done_lo", lo, 32'hB2);
    chk("wait_done_err", {31'b0, err}, 32'h0);

    // Timeout: 64 stalled cycles, abort cycle unstalled, then err pulse
    src_rdy  = 5'b11011;
    wr_valid = 1'b1;
    wr_sel   = 3'd2;
    for (int c = 0; c < 64; c++) begin
      #1;
      chk($sformatf("tmo_stall_c%0d", c), {31'b0, stall}, 32'h1);
      tick();
      wr_valid = 1'b0;
    end
    #1;
    chk("tmo_abort_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("tmo_err", {31'b0, err}, 32'h1);
    chk("tmo_hi", hi, 32'hA2);
    chk("tmo_lo", lo, 32'hB2);
    src_rdy  = 5'b11111;
    wr_valid = 1'b1;
    wr_sel   = 3'd1;
    tick();
    wr_valid = 1'b0;
    chk("tmo_err_pulse", {31'b0, err}, 32'h0);
    chk("after_tmo_hi", hi, 32'hA1);
    chk("after_tmo_lo", lo, 32'hB1);

    // Reset in the middle of a wait discards the pending write
    src_rdy  = 5'b11011;
    wr_valid = 1'b1;
    wr_sel   = 3'd2;
    tick();
    wr_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      chk($sformatf("rstw_stall_c%0d", c), {31'b0, stall}, 32'h1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rstw_hi", hi, 32'h0);
    chk("rstw_lo", lo, 32'h0);
    chk("rstw_stall", {31'b0, stall}, 32'h0);
    tick();
    rst     = 1'b0;
    src_rdy = 5'b11111;
    tick();
    tick();
    chk("rstw_late_rdy_hi", hi, 32'h0);
    chk("rstw_late_rdy_lo", lo, 32'h0);
    chk("rstw_late_rdy_stall", {31'b0, stall}, 32'h0);

    // Ready arrives in the timeout cycle: write wins, no err
    src_rdy  = 5'b11011;
    wr_valid = 1'b1;
    wr_sel   = 3'd2;
    wr_hi_en = 1'b1;
    wr_lo_en = 1'b0;
    rd_sel   = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      chk($sformatf("race_stall_c%0d", c), {31'b0, stall}, 32'h1);
      tick();
      wr_valid = 1'b0;
    end
    src_rdy = 5'b11111;
    #1;
    chk("race_stall", {31'b0, stall}, 32'h0);
    chk("race_bypass", rd_data, 32'hA2);
    tick();
    chk("race_hi", hi, 32'hA2);
    chk("race_lo", lo, 32'h0);
    chk("race_err", {31'b0, err}, 32'h0);
    tick();
    chk("race_err_after", {31'b0, err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
